// File: rtl/alu_mul_seq_if.sv
// Request/response bundle for the alu_mul_seq shift-add multiply sequencer.
// master = requester (CPU control), slave = alu_mul_seq.
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             prod_zr;
  logic             prod_ng;

  modport master (
    output start, op_a, op_b,
    input  busy, done, product, prod_zr, prod_ng
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, product, prod_zr, prod_ng
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle low-half multiplier that time-shares the external combinational ALU as a shift-add engine.
// Optional macro ALU_MUL_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are zero.
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     bus,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DBL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] product_q;
  logic             last_iter;

`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last_iter = ((mplr >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // Only the f bit ever differs between the idle (x&y of zeros) and add patterns.
  assign alu_zx = 1'b0;
  assign alu_nx = 1'b0;
  assign alu_zy = 1'b0;
  assign alu_ny = 1'b0;
  assign alu_no = 1'b0;

  always_comb begin
    alu_x = '0;
    alu_y = '0;
    alu_f = 1'b0;
    case (state)
      ADD: begin
        alu_x = acc;
        alu_y = mcand;
        alu_f = 1'b1;
      end
      DBL: begin
        alu_x = mcand;
        alu_y = mcand;
        alu_f = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state == ADD) || (state == DBL);
  assign bus.done    = (state == DONE);
  assign bus.product = product_q;
  assign bus.prod_zr = (product_q == '0);
  assign bus.prod_ng = product_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            mcand <= bus.op_a;
            mplr  <= bus.op_b;
            cnt   <= '0;
`ifdef ALU_MUL_EARLY_EXIT_EN
            if (bus.op_b == '0) begin
              product_q <= '0;
              state     <= DONE;
            end else begin
              state <= ADD;
            end
`else
            state <= ADD;
`endif
          end
        end
        ADD: begin
          if (mplr[0]) acc <= alu_out;
          state <= DBL;
        end
        DBL: begin
          mcand <= alu_out;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          // acc is final after the last ADD, so the product is latched on the DONE-entry edge.
          if (last_iter) begin
            product_q <= acc;
            state     <= DONE;
          end else begin
            state <= ADD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq with a behavioural ALU closing the loop.
// Build with +define+ALU_MUL_EARLY_EXIT_EN to exercise the early-exit variant.
module tb_alu_mul_seq;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no;

  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(16)) bus ();

  alu_mul_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_x  (alu_x),
    .alu_y  (alu_y),
    .alu_zx (zx),
    .alu_nx (nx),
    .alu_zy (zy),
    .alu_ny (ny),
    .alu_f  (f),
    .alu_no (no),
    .alu_out(alu_out)
  );

  // Hack-style combinational ALU
  logic [15:0] x1, x2, y1, y2, o1;
  assign x1      = zx ? 16'h0000 : alu_x;
  assign x2      = nx ? ~x1 : x1;
  assign y1      = zy ? 16'h0000 : alu_y;
  assign y2      = ny ? ~y1 : y1;
  assign o1      = f ? (x2 + y2) : (x2 & y2);
  assign alu_out = no ? ~o1 : o1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int m;
    m = -1;
    for (int i = 0; i < 16; i++) if (b[i]) m = i;
    if (!EARLY) return 32;
    return (m < 0) ? 0 : 2 * (m + 1);
  endfunction

  // Issue one start, then watch every cycle until a few cycles past done.
  // lat = number of clock edges after the accepting edge before done is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int ign_k,
                        output int lat, output int busy_n, output int pulses,
                        output int ctl_err, output int hold_err);
    logic [15:0] prev;
    prev     = bus.product;
    lat      = -1;
    busy_n   = 0;
    pulses   = 0;
    ctl_err  = 0;
    hold_err = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 16'hDEAD;
    bus.op_b  = 16'hBEEF;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == ign_k) begin
        bus.start = 1'b1;
        bus.op_a  = 16'd9;
        bus.op_b  = 16'd9;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (bus.busy) begin
        busy_n++;
        if ({zx, nx, zy, ny, f, no} != 6'b000010) ctl_err++;
      end else if ({zx, nx, zy, ny, f, no} != 6'b000000 || alu_x != 16'h0 || alu_y != 16'h0) begin
        ctl_err++;
      end
      if (lat < 0 && bus.product !== prev) hold_err++;
      if (lat >= 0 && k >= lat + 3) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expp, input int ign_k);
    int lat, busy_n, pulses, ctl_err, hold_err;
    run_op(a, b, ign_k, lat, busy_n, pulses, ctl_err, hold_err);
    chk({tag, ".product"}, bus.product, expp);
    chk({tag, ".prod_zr"}, bus.prod_zr, (expp == 16'h0));
    chk({tag, ".prod_ng"}, bus.prod_ng, expp[15]);
    chk({tag, ".latency"}, lat, exp_lat(b));
    chk({tag, ".busy_cycles"}, busy_n, exp_lat(b));
    chk({tag, ".done_pulses"}, pulses, 1);
    chk({tag, ".alu_ctl"}, ctl_err, 0);
    chk({tag, ".product_hold"}, hold_err, 0);
  endtask

  initial begin
    int d;
    bus.start = 1'b0;
    bus.op_a  = 16'h0;
    bus.op_b  = 16'h0;

    #12;
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.product", bus.product, 16'h0);
    chk("rst.prod_zr", bus.prod_zr, 1'b1);
    chk("rst.prod_ng", bus.prod_ng, 1'b0);
    chk("rst.alu_x", alu_x, 16'h0);
    chk("rst.alu_y", alu_y, 16'h0);
    chk("rst.alu_ctl", {zx, nx, zy, ny, f, no}, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // 2*7 with a stray 9*9 start while busy
    do_mul("ign", 16'd2, 16'd7, 16'h000E, EARLY ? 2 : 10);

    // 3*5 abandoned by reset ten cycles in
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 16'd3;
    bus.op_b  = 16'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.busy_before", bus.busy, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 1'b0);
    chk("abort.product", bus.product, 16'h0);
    chk("abort.prod_zr", bus.prod_zr, 1'b1);
    chk("abort.done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    d = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) d++;
    end
    chk("abort.no_activity", d, 0);

    do_mul("mul3x5", 16'd3, 16'd5, 16'h000F, -1);
    do_mul("wrapFFFF", 16'hFFFF, 16'hFFFF, 16'h0001, -1);
    do_mul("wrap300", 16'd300, 16'd300, 16'h5F90, -1);
    do_mul("signed", 16'hFFF9, 16'd6, 16'hFFD6, -1);
    do_mul("zero", 16'h1234, 16'h0000, 16'h0000, -1);
    do_mul("early3", 16'h0100, 16'h0003, 16'h0300, -1);
    do_mul("msb", 16'h0001, 16'h8000, 16'h8000, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 multiply sequencer. It computes the low WIDTH bits of a*b by time-sharing the existing combinational ALU as a shift-add engine.
- It drives the ALU operand buses and the six control bits (zx, nx, zy, ny, f, no) externally. It captures the ALU result into internal registers.
- Sits beside the ALU in the CPU datapath. It gives the ISA a MUL operation without adding a dedicated multiplier.

Parameters:
- WIDTH, 16, operand/product width; must match the ALU width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand, sampled with start.
- op_b  in  WIDTH  multiplier, sampled with start.
- busy  out  1  high while an operation is in progress (ADD/DBL).
- done  out  1  one-cycle pulse; product valid.
- product  out  WIDTH  low WIDTH bits of op_a*op_b; held until the next accepted start.
- prod_zr  out  1  product == 0.
- prod_ng  out  1  product[WIDTH-1].
- alu_x  out  WIDTH  ALU x operand.
- alu_y  out  WIDTH  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- alu_out  in  WIDTH  ALU result (combinational from alu_x/alu_y/controls).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all internal registers cleared (acc, mcand, mplr, cnt, product).
  - busy=0, done=0, product=0, prod_zr=1, prod_ng=0, alu_x=alu_y=0, all ALU control bits 0.
  - Reset asserted mid-operation abandons the operation immediately; no done is produced.
- States: IDLE, ADD, DBL, DONE.
- IDLE:
  - ALU driven x=y=0, controls all 0 (x&y → 0).
  - If start=1: acc<=0, mcand<=op_a, mplr<=op_b, cnt<=0, next state ADD.
- ADD:
  - ALU drives alu_x=acc, alu_y=mcand, controls zx=0 nx=0 zy=0 ny=0 f=1 no=0 (x+y).
  - At the clock edge: if mplr[0]=1 then acc<=alu_out; else acc unchanged. Next state DBL.
- DBL:
  - ALU drives alu_x=alu_y=mcand, same add controls.
  - At the clock edge: mcand<=alu_out, mplr<=mplr>>1 (logical), cnt<=cnt+1.
  - If cnt==WIDTH-1, go to DONE; else go to ADD.
- DONE:
  - product<=acc at entry.
  - done=1 for exactly one cycle; ALU driven as in IDLE; next state IDLE.
- busy=1 exactly in ADD and DBL.
- Latency (feature off): start sampled at edge E0; done high in the cycle after edge E0+2*WIDTH (32 ALU cycles + 1 DONE cycle); back-to-back start is accepted on the edge ending DONE+1 (IDLE).
- Arithmetic:
  - Adds wrap modulo 2^WIDTH; no carry or overflow is reported.
  - Results are identical for signed two's-complement and unsigned operands (low-half product).
- start while busy or in DONE is ignored; no queueing.
- Operands are sampled only at acceptance; op_a/op_b changes afterwards have no effect.
- product, prod_zr and prod_ng change only at DONE entry.
- prod_zr and prod_ng are combinational from the product register.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined:
  - In DBL, go to DONE when (mplr>>1)==0 or cnt==WIDTH-1, whichever occurs first.
  - In IDLE, a start with op_b==0 goes directly to DONE with product 0; busy never asserts in that case.
  - Latency = 2*(index of highest set bit of op_b + 1) cycles, then DONE.
- Undefined: fixed 2*WIDTH-cycle iteration regardless of op_b; the op_b==0 shortcut is absent.
- Results are identical in both builds.

Test Plan:
- Reset mid-run: start 3*5, assert rst_n=0 at cycle 10 → busy=0, product=0, prod_zr=1, no done pulse; after release, 3*5 → product=0x000F, done exactly 33 cycles after start edge (feature off).
- Wrap: op_a=0xFFFF, op_b=0xFFFF → product=0x0001, prod_ng=0; op_a=300, op_b=300 → product=0x5F90.
- Signed: op_a=0xFFF9 (-7), op_b=6 → product=0xFFD6, prod_ng=1, prod_zr=0.
- Zero: op_a=0x1234, op_b=0 → product=0x0000, prod_zr=1; with ALU_MUL_EARLY_EXIT_EN, done the cycle after start and busy never high.
- Ignored start: pulse start with op_a=9, op_b=9 during busy of a 2*7 operation → product=0x000E; only one done pulse; ALU controls are the add pattern (f=1, other controls 0) in every ADD/DBL cycle.
- Early exit: with ALU_MUL_EARLY_EXIT_EN, op_a=0x0100, op_b=0x0003 → product=0x0300, done after 4 ALU cycles; op_b=0x8000 → 32 cycles.
